// File: rtl/sdc_data_serializer.sv
// SD-card DAT0 write-path serializer: start bit, BLOCK_BYTES data bytes MSB first,
// CRC16-CCITT, end bit. Bytes are fetched through a ready/valid handshake that never stalls.
module sdc_data_serializer #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [15:0] CRC_INIT    = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_dat_out,
    output logic        o_dat_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun,
    output logic [15:0] o_crc_value
);
    localparam int unsigned     CntW     = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StCrc, StEnd} state_e;

    state_e            r_state, w_state_nxt;
    logic [6:0]        r_shift, w_shift_nxt;
    logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [CntW-1:0]   r_byte_cnt, w_byte_cnt_nxt;
    logic [3:0]        r_crc_cnt, w_crc_cnt_nxt;
    logic [15:0]       r_crc, w_crc_nxt;
    logic [15:0]       r_crc_save, w_crc_save_nxt;
    logic              r_dat_out, w_dat_out_nxt;
    logic              r_dat_oe, w_dat_oe_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_underrun, w_underrun_nxt;
    logic [7:0]        w_fetch_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        // A missing byte is replaced by zero so the line timing never slips.
        w_fetch_byte    = i_byte_valid ? i_byte_in : 8'h00;
        o_byte_ready    = (r_state == StStart) ||
                          ((r_state == StData) && (r_bit_cnt == 3'd7) && (r_byte_cnt != LastByte));
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_crc_cnt_nxt   = r_crc_cnt;
        w_crc_nxt       = r_crc;
        w_crc_save_nxt  = r_crc_save;
        w_dat_out_nxt   = r_dat_out;
        w_dat_oe_nxt    = r_dat_oe;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_underrun_nxt  = r_underrun;

        if (o_byte_ready) begin
            w_shift_nxt = w_fetch_byte[6:0];
            if (!i_byte_valid) begin
                w_underrun_nxt = 1'b1;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt    = StStart;
                    w_dat_out_nxt  = 1'b0;
                    w_dat_oe_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_underrun_nxt = 1'b0;
                    w_crc_nxt      = CRC_INIT;
                end
            end
            StStart: begin
                w_state_nxt    = StData;
                w_dat_out_nxt  = w_fetch_byte[7];
                w_crc_nxt      = crc_step(r_crc, w_fetch_byte[7]);
                w_bit_cnt_nxt  = 3'd0;
                w_byte_cnt_nxt = '0;
            end
            StData: begin
                if (r_bit_cnt != 3'd7) begin
                    w_dat_out_nxt = r_shift[6];
                    w_shift_nxt   = {r_shift[5:0], 1'b0};
                    w_crc_nxt     = crc_step(r_crc, r_shift[6]);
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                end else if (r_byte_cnt != LastByte) begin
                    w_dat_out_nxt  = w_fetch_byte[7];
                    w_crc_nxt      = crc_step(r_crc, w_fetch_byte[7]);
                    w_bit_cnt_nxt  = 3'd0;
                    w_byte_cnt_nxt = r_byte_cnt + CntW'(1);
                end else begin
                    // Keep a copy: the CRC register is consumed as it shifts out.
                    w_state_nxt    = StCrc;
                    w_dat_out_nxt  = r_crc[15];
                    w_crc_nxt      = {r_crc[14:0], 1'b0};
                    w_crc_save_nxt = r_crc;
                    w_crc_cnt_nxt  = 4'd0;
                end
            end
            StCrc: begin
                if (r_crc_cnt != 4'd15) begin
                    w_dat_out_nxt = r_crc[15];
                    w_crc_nxt     = {r_crc[14:0], 1'b0};
                    w_crc_cnt_nxt = r_crc_cnt + 4'd1;
                end else begin
                    w_state_nxt   = StEnd;
                    w_dat_out_nxt = 1'b1;
                    w_crc_nxt     = r_crc_save;
                end
            end
            StEnd: begin
                w_state_nxt   = StIdle;
                w_dat_out_nxt = 1'b1;
                w_dat_oe_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_crc_cnt  <= '0;
            r_crc      <= CRC_INIT;
            r_crc_save <= CRC_INIT;
            r_dat_out  <= 1'b1;
            r_dat_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_crc_cnt  <= w_crc_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_crc_save <= w_crc_save_nxt;
            r_dat_out  <= w_dat_out_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign o_dat_out   = r_dat_out;
    assign o_dat_oe    = r_dat_oe;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_underrun  = r_underrun;
    assign o_crc_value = r_crc;

endmodule

// File: tb/tb_sdc_data_serializer.sv
// Scoreboard bench: a byte-level frame model queues expected DAT0 frames; a monitor
// captures each dat_oe window and compares it against the queued expectation.
module tb_sdc_data_serializer;
    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_in;
    bit          sel;
    bit          noise;
    logic        a_start, b_start;
    logic        a_ready, a_dat, a_oe, a_busy, a_done, a_und;
    logic        b_ready, b_dat, b_oe, b_busy, b_done, b_und;
    logic [15:0] a_crc, b_crc;
    logic        m_ready, m_dat, m_oe, m_done, m_und;
    logic [15:0] m_crc;

    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_dat   = sel ? b_dat   : a_dat;
    assign m_oe    = sel ? b_oe    : a_oe;
    assign m_done  = sel ? b_done  : a_done;
    assign m_und   = sel ? b_und   : a_und;
    assign m_crc   = sel ? b_crc   : a_crc;

    sdc_data_serializer #(.BLOCK_BYTES(512), .CRC_INIT(16'h0000)) u_dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(a_start), .i_byte_in(byte_in),
        .i_byte_valid(byte_valid), .o_byte_ready(a_ready), .o_dat_out(a_dat),
        .o_dat_oe(a_oe), .o_busy(a_busy), .o_done(a_done), .o_underrun(a_und),
        .o_crc_value(a_crc)
    );

    sdc_data_serializer #(.BLOCK_BYTES(1), .CRC_INIT(16'h0000)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(b_start), .i_byte_in(byte_in),
        .i_byte_valid(byte_valid), .o_byte_ready(b_ready), .o_dat_out(b_dat),
        .o_dat_oe(b_oe), .o_busy(b_busy), .o_done(b_done), .o_underrun(b_und),
        .o_crc_value(b_crc)
    );

    typedef struct {
        int          len;
        logic [15:0] crc;
        logic        und;
        int          fetches;
        bit          aborted;
        bit          b2b;
    } blk_t;

    blk_t       exp_blk[$];
    bit         exp_bits[$];
    logic [7:0] stg_data[$];
    bit         stg_valid[$];
    logic [7:0] drv_bytes[$];
    bit         drv_valid[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Frame model: byte-wise CRC16-CCITT over the bytes actually sent.
    task automatic push_block(input bit aborted, input bit b2b, input bit ovr,
                              input logic [15:0] ovr_crc);
        blk_t        r;
        logic [15:0] c;
        logic [7:0]  b;
        bit          any_miss;
        int          n;
        n = stg_data.size();
        c = 16'h0000;
        any_miss = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = stg_valid[i] ? stg_data[i] : 8'h00;
            if (!stg_valid[i]) any_miss = 1'b1;
            c = c ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        if (ovr) c = ovr_crc;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            b = stg_valid[i] ? stg_data[i] : 8'h00;
            for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
        end
        for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
        exp_bits.push_back(1'b1);
        r.len = 8 * n + 18;
        r.crc = c;
        r.und = any_miss && !aborted;
        r.fetches = n;
        r.aborted = aborted;
        r.b2b = b2b;
        exp_blk.push_back(r);
        for (int i = 0; i < n; i++) begin
            drv_bytes.push_back(stg_data[i]);
            drv_valid.push_back(stg_valid[i]);
        end
        stg_data.delete();
        stg_valid.delete();
    endtask

    // Driver: answers each byte_ready with the next queued byte; noise elsewhere.
    always @(negedge clk) begin
        if (m_ready) begin
            if (drv_bytes.size() > 0) begin
                byte_in = drv_bytes.pop_front();
                byte_valid = drv_valid.pop_front();
            end else begin
                byte_in = 8'($urandom);
                byte_valid = 1'b0;
            end
        end else if (noise) begin
            byte_in = 8'($urandom);
            byte_valid = 1'($urandom_range(0, 1));
        end else begin
            byte_valid = 1'b1;
        end
    end

    bit          in_frame = 1'b0;
    bit          cap[$];
    int          fetches = 0;
    int          stray_done = 0;
    int          idle_cnt = 2;
    int          mon_frames = 0;
    logic [15:0] last_crc;

    task automatic end_frame();
        blk_t r;
        int   mis;
        bit   e;
        mis = -1;
        if (exp_blk.size() == 0) begin
            chk("unexpected_frame_len", cap.size(), 0);
        end else begin
            r = exp_blk.pop_front();
            for (int i = 0; i < r.len; i++) begin
                e = exp_bits.pop_front();
                if (mis < 0 && i < cap.size() && cap[i] !== e) mis = i;
            end
            if (r.aborted) begin
                chk("abort_frame_short", int'(cap.size() < r.len), 1);
                chk("abort_no_done", int'(m_done), 0);
            end else begin
                chk("frame_len", cap.size(), r.len);
                chk("crc_value_in_end", int'(last_crc), int'(r.crc));
                chk("underrun_at_done", int'(m_und), int'(r.und));
                chk("done_pulse", int'(m_done), 1);
                chk("byte_fetches", fetches, r.fetches);
            end
            chk("frame_first_bad_bit", mis, -1);
            chk("stray_done", stray_done, 0);
        end
        stray_done = 0;
        fetches = 0;
        mon_frames++;
    endtask

    always @(negedge clk) begin
        if (m_ready) fetches++;
        if (m_oe) begin
            if (m_done) stray_done++;
            if (!in_frame) begin
                in_frame = 1'b1;
                cap.delete();
                chk("underrun_clear_at_start", int'(m_und), 0);
                if (exp_blk.size() > 0 && exp_blk[0].b2b) chk("b2b_idle_gap", idle_cnt, 1);
            end
            cap.push_back(m_dat);
            last_crc = m_crc;
        end else if (in_frame) begin
            in_frame = 1'b0;
            end_frame();
            idle_cnt = 1;
        end else begin
            if (m_done) stray_done++;
            idle_cnt++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (mon_frames < target && t < 9000) begin
            @(negedge clk);
            t++;
        end
        if (mon_frames < target) chk("frame_timeout", mon_frames, target);
    endtask

    task automatic stage_random(input int n);
        for (int i = 0; i < n; i++) begin
            stg_data.push_back(8'($urandom));
            stg_valid.push_back(1'b1);
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        sel = 1'b0;
        noise = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dat_out", int'(a_dat), 1);
        chk("rst_dat_oe", int'(a_oe), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_underrun", int'(a_und), 0);
        chk("rst_byte_ready", int'(a_ready), 0);
        chk("rst_crc_value", int'(a_crc), 0);
        chk("rst_b_dat_oe", int'(b_oe), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset during byte 100, then a fresh random block.
        stage_random(512);
        push_block(1'b1, 1'b0, 1'b0, 16'h0000);
        pulse_start();
        repeat (1 + 800 + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_dat_oe", int'(a_oe), 0);
        chk("midrst_dat_out", int'(a_dat), 1);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_done", int'(a_done), 0);
        drv_bytes.delete();
        drv_valid.delete();
        wait_frames(1);
        stage_random(512);
        push_block(1'b0, 1'b0, 1'b0, 16'h0000);
        pulse_start();
        wait_frames(2);

        // All 0xFF with valid held high: known CRC 0x7FA1.
        noise = 1'b0;
        for (int i = 0; i < 512; i++) begin
            stg_data.push_back(8'hFF);
            stg_valid.push_back(1'b1);
        end
        push_block(1'b0, 1'b0, 1'b1, 16'h7FA1);
        pulse_start();
        wait_frames(3);
        noise = 1'b1;

        // All zeros: CRC 0x0000, 4114-cycle dat_oe window.
        for (int i = 0; i < 512; i++) begin
            stg_data.push_back(8'h00);
            stg_valid.push_back(1'b1);
        end
        push_block(1'b0, 1'b0, 1'b1, 16'h0000);
        pulse_start();
        wait_frames(4);

        // Incrementing bytes, byte 3 missing.
        for (int i = 0; i < 512; i++) begin
            stg_data.push_back(8'(i));
            stg_valid.push_back(i != 3);
        end
        push_block(1'b0, 1'b0, 1'b0, 16'h0000);
        pulse_start();
        wait_frames(5);

        // Start mid-DATA ignored; start in the done cycle chains a second block.
        stage_random(512);
        push_block(1'b0, 1'b0, 1'b0, 16'h0000);
        stage_random(512);
        push_block(1'b0, 1'b1, 1'b0, 16'h0000);
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_start();
        t = 0;
        while (!a_done && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (!a_done) chk("done_wait_timeout", int'(a_done), 1);
        pulse_start();
        wait_frames(7);

        // Single-byte blocks.
        sel = 1'b1;
        @(negedge clk);
        stg_data.push_back(8'hA5);
        stg_valid.push_back(1'b1);
        push_block(1'b0, 1'b0, 1'b0, 16'h0000);
        pulse_start();
        wait_frames(8);
        for (int j = 0; j < 3; j++) begin
            stg_data.push_back(8'($urandom));
            stg_valid.push_back(1'($urandom_range(0, 1)));
            push_block(1'b0, 1'b0, 1'b0, 16'h0000);
            pulse_start();
            wait_frames(9 + j);
            repeat (2) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
